fetch_sequencer: RTL and testbench

//   Sequences the instruction-fetch stage. Owns the PC and issues one request at
//   a time to instruction memory. Captures the returned word into the IF/ID

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/pc_next_sel.sv | 24 ++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_KEEP   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: hold, sequential step, or word-aligned redirect.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic    [31:0] pc,
  input  pc_sel_e        sel,
  input  logic    [31:0] branch_target,
  output logic    [31:0] next_pc
);

  // Select the PC for the next edge; the sequential step wraps modulo 2^32.
  always_comb begin
    next_pc = pc;
    case (sel)
      PC_KEEP:   next_pc = pc;
      PC_SEQ:    next_pc = pc + 32'(PC_STEP);
      PC_BRANCH: next_pc = word_align(branch_target);
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight,
// captures returned words into IF/ID, and honours stalls and branch flushes.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_npc
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic         drop_r;
  pc_sel_e      pc_sel_s;
  logic [31:0]  pc_next_s;
  logic         consume_s;
  logic         capture_s;

  // Decode this edge's IF/ID events and the PC source; a redirect beats everything.
  always_comb begin
    consume_s = if_valid && !stall && !pcsrc;
    capture_s = (state_r == WAIT) && imem_ack && !drop_r && !pcsrc;
    pc_sel_s  = PC_KEEP;
    if (pcsrc) begin
      pc_sel_s = PC_BRANCH;
    end else if (capture_s) begin
      pc_sel_s = PC_SEQ;
    end else begin
      pc_sel_s = PC_KEEP;
    end
  end

  pc_next_sel #(
    .PC_STEP(PC_STEP)
  ) u_pc_next_sel (
    .pc           (pc_r),
    .sel          (pc_sel_s),
    .branch_target(branch_target),
    .next_pc      (pc_next_s)
  );

  // Fetch FSM, drop flag, request port and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH;
      pc_r      <= RESET_PC;
      drop_r    <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0000_0000;
      if_valid  <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_npc    <= 32'h0000_0000;
    end else begin
      imem_req <= 1'b0;
      pc_r     <= pc_next_s;

      if (pcsrc) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end else if (capture_s) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_npc   <= pc_next_s;
      end else if (consume_s) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end

      case (state_r)
        FETCH: begin
          imem_req  <= 1'b1;
          imem_addr <= pc_r;
          state_r   <= WAIT;
          // A redirect on the issuing edge leaves a stale request in flight.
          if (pcsrc) begin
            drop_r <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            drop_r <= 1'b0;
            if (pcsrc || drop_r || !stall) begin
              state_r <= FETCH;
            end else begin
              state_r <= HOLD;
            end
          end else if (pcsrc) begin
            drop_r <= 1'b1;
          end
        end
        HOLD: begin
          if (pcsrc || !stall) begin
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_npc;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] W1 = 32'h0108_4820;
  localparam logic [31:0] W2 = 32'h0109_5022;

  fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pcsrc        (pcsrc),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_npc       (if_npc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, release, one edge: the first request is then on the port.
  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; pcsrc = 1'b1; branch_target = 32'h40;
    imem_ack = 1'b1; imem_rdata = W1;
    tick(); tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    total++; if (if_npc !== 32'h0) begin bad++; $display("FAIL reset_npc got=%h exp=0", if_npc); end
    rst = 1'b0; stall = 1'b0; pcsrc = 1'b0; imem_ack = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL first_valid got=%b exp=0", if_valid); end
  endtask

  task automatic test_sequential();
    reset_dut();
    tick();
    imem_ack = 1'b1; imem_rdata = W1;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b1 || if_instr !== W1) begin bad++; $display("FAIL seq_cap1 got=%b/%h exp=1/%h", if_valid, if_instr, W1); end
    total++; if (if_npc !== 32'h4) begin bad++; $display("FAIL seq_npc1 got=%h exp=4", if_npc); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL seq_addr4 got=%b/%h exp=1/4", imem_req, imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL seq_consumed got=%b exp=0", if_valid); end
    tick();
    imem_ack = 1'b1; imem_rdata = W2;
    tick();
    imem_ack = 1'b0;
    total++; if (if_instr !== W2 || if_npc !== 32'h8) begin bad++; $display("FAIL seq_cap2 got=%h/%h exp=%h/8", if_instr, if_npc, W2); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL seq_addr8 got=%b/%h exp=1/8", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    reset_dut();
    tick();
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = W1;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b1 || if_instr !== W1) begin bad++; $display("FAIL stall_cap got=%b/%h exp=1/%h", if_valid, if_instr, W1); end
    for (int i = 0; i < 3; i++) begin
      imem_ack = (i == 1);
      imem_rdata = 32'hBAD0_0BAD;
      tick();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_noreq got=%b exp=0 cycle=%0d", imem_req, i); end
      total++; if (if_valid !== 1'b1 || if_instr !== W1) begin bad++; $display("FAIL stall_hold got=%b/%h exp=1/%h", if_valid, if_instr, W1); end
    end
    imem_ack = 1'b0; stall = 1'b0;
    tick();
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL stall_release got=%b/%b exp=0/0", if_valid, imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL stall_next got=%b/%h exp=1/4", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    reset_dut();
    pcsrc = 1'b1; branch_target = 32'h23;
    tick();
    pcsrc = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rdw_valid got=%b exp=0", if_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin bad++; $display("FAIL rdw_discard got=%b/%h exp=0/0", if_valid, if_instr); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin bad++; $display("FAIL rdw_addr got=%b/%h exp=1/20", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_stall();
    reset_dut();
    tick();
    imem_ack = 1'b1; imem_rdata = W1;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL rds_pre got=%b exp=1", if_valid); end
    stall = 1'b1; pcsrc = 1'b1; branch_target = 32'h100;
    tick();
    stall = 1'b0; pcsrc = 1'b0;
    total++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin bad++; $display("FAIL rds_flush got=%b/%h exp=0/0", if_valid, if_instr); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rds_drop got=%b exp=0", if_valid); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL rds_target got=%b/%h exp=1/100", imem_req, imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    reset_dut();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = W1;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rstw_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rstw_valid got=%b exp=0", if_valid); end
    tick();
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rstw_stale got=%b/%b exp=0/0", if_valid, imem_req); end
  endtask

  task automatic test_wrap();
    reset_dut();
    pcsrc = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    pcsrc = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%b/%h exp=1/fffffffc", imem_req, imem_addr); end
    tick();
    imem_ack = 1'b1; imem_rdata = W2;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b1 || if_npc !== 32'h0) begin bad++; $display("FAIL wrap_npc got=%b/%h exp=1/0", if_valid, if_npc); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  // Model tracks the expected fetch stream: the PC, the single outstanding
  // request (and whether a redirect orphaned it), and the IF/ID contents.
  task automatic test_random();
    logic        have_out, out_drop, exp_valid, prev_valid, cap, st, ps, ak;
    logic [31:0] out_addr, model_pc, pc_before, exp_instr, exp_npc, tgt, rd;
    int          wait_cnt, caps;
    reset_dut();
    have_out = 1'b1; out_drop = 1'b0; out_addr = 32'h0; model_pc = 32'h0;
    wait_cnt = $urandom_range(1, 3);
    exp_valid = 1'b0; exp_instr = 32'h0; exp_npc = 32'h0; caps = 0;
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      rd  = $urandom;
      ak  = 1'b0;
      if (have_out) begin
        if (wait_cnt == 0) ak = 1'b1;
        else wait_cnt--;
      end
      stall = st; pcsrc = ps; branch_target = tgt; imem_ack = ak; imem_rdata = rd;
      prev_valid = exp_valid; pc_before = model_pc; cap = 1'b0;
      tick();
      if (ak) begin
        have_out = 1'b0;
        cap = !out_drop && !ps;
      end
      if (ps) begin
        model_pc = tgt & 32'hFFFF_FFFC;
        exp_valid = 1'b0; exp_instr = 32'h0;
        if (have_out) out_drop = 1'b1;
      end else if (cap) begin
        exp_valid = 1'b1; exp_instr = rd; exp_npc = out_addr + 32'd4;
        model_pc = exp_npc; caps++;
      end else if (prev_valid && !st) begin
        exp_valid = 1'b0; exp_instr = 32'h0;
      end
      total++; if (if_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, if_valid, exp_valid); end
      total++; if (if_instr !== exp_instr) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", c, if_instr, exp_instr); end
      total++; if (if_npc !== exp_npc) begin bad++; $display("FAIL rnd_npc cyc=%0d got=%h exp=%h", c, if_npc, exp_npc); end
      if (imem_req === 1'b1) begin
        total++; if (have_out !== 1'b0) begin bad++; $display("FAIL rnd_outstanding cyc=%0d got=2 exp=1", c); end
        total++; if (imem_addr !== pc_before) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, imem_addr, pc_before); end
        have_out = 1'b1; out_addr = pc_before; out_drop = ps;
        wait_cnt = $urandom_range(1, 3);
      end
    end
    stall = 1'b0; pcsrc = 1'b0; imem_ack = 1'b0;
    total++; if (caps < 100) begin bad++; $display("FAIL rnd_progress got=%0d exp>=100", caps); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
